// File: rtl/mux_arb_pkg.sv
// Shared state encoding and mux select codes for the 2:1 round-robin arbiter.
package mux_arb_pkg;

    // Arbiter FSM states; encoding fixed so the values stay stable across tools.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_A = 2'd1,
        BUSY_B = 2'd2
    } arb_state_t;

    // Mux select codes, also reported on out_sel.
    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux_2to1_d.sv
// Plain combinational 2:1 datapath mux.
module mux_2to1_d #(
    parameter int width = 1
) (
    input  logic             sel,
    input  logic [width-1:0] d0,
    input  logic [width-1:0] d1,
    output logic [width-1:0] y
);

    // sel=0 routes d0, sel=1 routes d1.
    always_comb begin
        y = sel ? d1 : d0;
    end

endmodule

// File: rtl/mux_2to1_rr_arbiter.sv
// Two valid/ready packet requesters share one 2:1 datapath. Round-robin grant,
// locked until the last beat of the packet is accepted, into one output register.
import mux_arb_pkg::*;

module mux_2to1_rr_arbiter #(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    input  logic [width-1:0] a_data,
    input  logic             a_last,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [width-1:0] b_data,
    input  logic             b_last,
    output logic             b_ready,
    output logic             out_valid,
    output logic [width-1:0] out_data,
    output logic             out_last,
    output logic             out_sel,
    input  logic             out_ready
);

    arb_state_t   state;
    logic         rr_ptr;     // 0: A preferred on contention, 1: B preferred
    logic         can_load;
    logic         grant_sel;
    logic         accept;
    logic [width:0] mux_y;    // {last, data} of the granted source

    // Ready is purely a function of grant and output register occupancy.
    always_comb begin
        can_load  = ~out_valid | out_ready;
        grant_sel = (state == BUSY_B) ? SEL_B : SEL_A;
        a_ready   = (state == BUSY_A) & can_load;
        b_ready   = (state == BUSY_B) & can_load;
        accept    = (a_valid & a_ready) | (b_valid & b_ready);
    end

    mux_2to1_d #(
        .width(width + 1)
    ) u_mux (
        .sel(grant_sel),
        .d0 ({a_last, a_data}),
        .d1 ({b_last, b_data}),
        .y  (mux_y)
    );

    // Grant FSM, round-robin pointer and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_sel   <= SEL_A;
        end else begin
            // Load wins over drain; a concurrent drain+load is full throughput.
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= mux_y[width-1:0];
                out_last  <= mux_y[width];
                out_sel   <= grant_sel;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    if (a_valid && (!b_valid || !rr_ptr)) begin
                        state <= BUSY_A;
                    end else if (b_valid) begin
                        state <= BUSY_B;
                    end
                end
                BUSY_A: begin
                    if (a_valid && a_ready && a_last) begin
                        state  <= IDLE;
                        rr_ptr <= 1'b1;
                    end
                end
                BUSY_B: begin
                    if (b_valid && b_ready && b_last) begin
                        state  <= IDLE;
                        rr_ptr <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_2to1_rr_arbiter.sv
// Directed self-checking bench for mux_2to1_rr_arbiter.
module tb_mux_2to1_rr_arbiter;

    localparam int width = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             a_valid, a_last, a_ready;
    logic [width-1:0] a_data;
    logic             b_valid, b_last, b_ready;
    logic [width-1:0] b_data;
    logic             out_valid, out_last, out_sel, out_ready;
    logic [width-1:0] out_data;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mux_2to1_rr_arbiter #(
        .width(width)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .a_valid  (a_valid),
        .a_data   (a_data),
        .a_last   (a_last),
        .a_ready  (a_ready),
        .b_valid  (b_valid),
        .b_data   (b_data),
        .b_last   (b_last),
        .b_ready  (b_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_last (out_last),
        .out_sel  (out_sel),
        .out_ready(out_ready)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge and let registered outputs settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) tick();
        rst = 1'b0;
    endtask

    logic [width-1:0] a_seq [2];
    logic [width-1:0] b_seq [2];
    logic [width-1:0] cap_data [32];
    logic             cap_sel  [32];
    logic [width-1:0] exp_data [6];
    logic             exp_sel  [6];

    initial begin
        int n_cap;
        int a_idx;
        int b_idx;
        logic acc_a;
        logic acc_b;

        rst = 1'b1;
        a_valid = 1'b0; a_data = '0; a_last = 1'b0;
        b_valid = 1'b0; b_data = '0; b_last = 1'b0;
        out_ready = 1'b0;

        // Reset then idle.
        do_reset(2);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_data", out_data, 32'h0);
        check_eq("rst_out_last", out_last, 0);
        check_eq("rst_out_sel", out_sel, 0);
        out_ready = 1'b1;
        #1;
        check_eq("rst_a_ready", a_ready, 0);
        check_eq("rst_b_ready", b_ready, 0);
        tick();
        check_eq("idle_a_ready", a_ready, 0);

        // Single-beat A packet.
        a_valid = 1'b1; a_data = 32'hA000_0000; a_last = 1'b1;
        tick();
        check_eq("single_grant_a_ready", a_ready, 1);
        check_eq("single_not_yet_valid", out_valid, 0);
        tick();
        check_eq("single_out_valid", out_valid, 1);
        check_eq("single_out_data", out_data, 32'hA000_0000);
        check_eq("single_out_sel", out_sel, 0);
        check_eq("single_out_last", out_last, 1);
        check_eq("single_back_idle", a_ready, 0);
        a_valid = 1'b0;
        tick();
        check_eq("single_drain_valid", out_valid, 0);
        check_eq("single_drain_hold", out_data, 32'hA000_0000);

        // rr_ptr now favours B on contention.
        a_valid = 1'b1; b_valid = 1'b1;
        tick();
        check_eq("rr_b_pref_b_ready", b_ready, 1);
        check_eq("rr_b_pref_a_ready", a_ready, 0);
        a_valid = 1'b0; b_valid = 1'b0;
        do_reset(1);

        // Contention: continuous 2-beat packets from both sides.
        a_seq[0] = 32'hA000_0000; a_seq[1] = 32'hB000_0000;
        b_seq[0] = 32'hC000_0000; b_seq[1] = 32'hD000_0000;
        exp_data[0] = 32'hA000_0000; exp_sel[0] = 1'b0;
        exp_data[1] = 32'hB000_0000; exp_sel[1] = 1'b0;
        exp_data[2] = 32'hC000_0000; exp_sel[2] = 1'b1;
        exp_data[3] = 32'hD000_0000; exp_sel[3] = 1'b1;
        exp_data[4] = 32'hA000_0000; exp_sel[4] = 1'b0;
        exp_data[5] = 32'hB000_0000; exp_sel[5] = 1'b0;
        n_cap = 0; a_idx = 0; b_idx = 0;
        out_ready = 1'b1;
        a_valid = 1'b1; b_valid = 1'b1;
        for (int cyc = 0; cyc < 16; cyc++) begin
            a_data = a_seq[a_idx]; a_last = (a_idx == 1);
            b_data = b_seq[b_idx]; b_last = (b_idx == 1);
            #1;
            if (out_valid && out_ready) begin
                cap_data[n_cap] = out_data;
                cap_sel[n_cap]  = out_sel;
                n_cap++;
            end
            acc_a = a_valid & a_ready;
            acc_b = b_valid & b_ready;
            check_eq("cont_no_dual_ready", {31'd0, a_ready & b_ready}, 0);
            tick();
            if (acc_a) a_idx = 1 - a_idx;
            if (acc_b) b_idx = 1 - b_idx;
        end
        check_eq("cont_beat_count", (n_cap >= 6) ? 1 : 0, 1);
        for (int i = 0; i < 6; i++) begin
            if (i < n_cap) begin
                check_eq($sformatf("cont_data_%0d", i), cap_data[i], exp_data[i]);
                check_eq($sformatf("cont_sel_%0d", i), cap_sel[i], exp_sel[i]);
            end
        end
        a_valid = 1'b0; b_valid = 1'b0; a_last = 1'b0; b_last = 1'b0;
        do_reset(1);

        // Backpressure in the middle of a 3-beat A packet.
        out_ready = 1'b1;
        a_valid = 1'b1; a_data = 32'h1111_1111; a_last = 1'b0;
        tick();
        tick();
        check_eq("bp_first_beat", out_data, 32'h1111_1111);
        a_data = 32'h2222_2222;
        out_ready = 1'b0;
        #1;
        check_eq("bp_a_ready_low", a_ready, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq($sformatf("bp_hold_data_%0d", i), out_data, 32'h1111_1111);
            check_eq($sformatf("bp_hold_valid_%0d", i), out_valid, 1);
            check_eq($sformatf("bp_hold_ready_%0d", i), a_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        check_eq("bp_release_ready", a_ready, 1);
        tick();
        check_eq("bp_second_beat", out_data, 32'h2222_2222);
        check_eq("bp_second_last", out_last, 0);
        a_data = 32'h3333_3333; a_last = 1'b1;
        tick();
        check_eq("bp_third_beat", out_data, 32'h3333_3333);
        check_eq("bp_third_last", out_last, 1);
        a_valid = 1'b0; a_last = 1'b0;
        tick();
        check_eq("bp_drained", out_valid, 0);
        do_reset(1);

        // Grant lock: A stalls mid-packet while B waits.
        out_ready = 1'b1;
        a_valid = 1'b1; a_data = 32'hF100_0000; a_last = 1'b0;
        b_valid = 1'b1; b_data = 32'hC000_0000; b_last = 1'b0;
        tick();
        tick();
        check_eq("lock_first_beat", out_data, 32'hF100_0000);
        a_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq($sformatf("lock_b_ready_%0d", i), b_ready, 0);
            tick();
            check_eq($sformatf("lock_out_sel_%0d", i), out_sel, 0);
        end
        a_valid = 1'b1; a_data = 32'hE000_0000; a_last = 1'b1;
        tick();
        check_eq("lock_last_data", out_data, 32'hE000_0000);
        check_eq("lock_last_flag", out_last, 1);
        check_eq("lock_last_sel", out_sel, 0);
        a_valid = 1'b0; a_last = 1'b0;
        tick();
        check_eq("lock_b_granted", b_ready, 1);
        tick();
        check_eq("lock_b_data", out_data, 32'hC000_0000);
        check_eq("lock_b_sel", out_sel, 1);
        check_eq("lock_b_valid", out_valid, 1);

        // Reset mid-packet while BUSY_B holds a beat.
        a_valid = 1'b1; a_data = 32'h5555_5555; a_last = 1'b1;
        b_data = 32'hD000_0000;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("mid_rst_out_valid", out_valid, 0);
        check_eq("mid_rst_out_data", out_data, 32'h0);
        check_eq("mid_rst_b_ready", b_ready, 0);
        check_eq("mid_rst_a_ready", a_ready, 0);
        tick();
        check_eq("mid_rst_a_first", a_ready, 1);
        check_eq("mid_rst_b_blocked", b_ready, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
